vect_stream_loader: RTL and testbench
=====================================

# vect_stream_loader

Sequencing controller that fills an `N_MAX`-element vector register bank one element per cycle from a valid/ready stream, then presents the assembled vector downstream with a valid/ready handshake. It sits in front of the vector datapath stages and turns serial element traffic (memory reads, scalar units) into the packed `N_MAX*WIDTH` vector bus the matrix pipeline consumes. It also handles runtime vector length, the global stall enable and back-to-back vectors.

## Interface
- `WIDTH`, 43, element width in bits
- `LEN_W`, 8, width of length fields; must satisfy 2^LEN_W > `N_MAX`
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  global advance enable; low freezes all state
- `start`  in  1  begin loading a vector, single-cycle pulse
- `len`  in  LEN_W  element count for this vector, sampled with `start`
- `busy`  out  1  high in LOAD or HOLD
- `in_valid`  in  1  source element valid
- `in_ready`  out  1  loader accepts an element this cycle
- `in_data`  in  WIDTH  source element
- `out_valid`  out  1  assembled vector available
- `out_ready`  in  1  consumer accepts the vector
- `vect_out`  out  `N_MAX`*WIDTH  packed vector; element i at bits [i*WIDTH +: WIDTH]
- `out_len`  out  LEN_W  effective length of the vector in `vect_out`

## Operation
- States: IDLE, LOAD, HOLD. Internal `idx` (LEN_W bits), `len_q` (LEN_W bits).
- Effective length `len_eff` = `N_MAX` if `len`==0 or `len`>`N_MAX`, else `len`.
- IDLE: `in_ready`=0. On `start`&`en`: `len_q`<=`len_eff`, `idx`<=0, go to LOAD.
- LOAD: `in_ready`=`en`. On `in_valid`&`in_ready`: element `idx`<=`in_data`, `idx`<=`idx`+1. If `idx`==`len_q`-1 on accept: `out_len`<=`len_q`, `out_valid`<=1, go to HOLD.
- HOLD: `out_valid`=1, `vect_out` and `out_len` stable. On `out_ready`&`en`: `out_valid`<=0. Go to IDLE, or to LOAD when `start` is also high in the same cycle. The new `len` is latched and `idx` is cleared in that case.
- `start` while in LOAD, or in HOLD without `out_ready`, is ignored. It is not queued.
- `in_valid` outside LOAD is ignored, and no element is written.
- `en`=0: no state, `idx`, bank or output register changes. `in_ready` is forced to 0. `out_valid` holds its value.
- `vect_out` is a registered bank. Elements not written in the current load keep their prior contents, unless the Configuration feature is compiled in.

## Timing
- Reset values: state IDLE, `idx`=0, `len_q`=0, `out_len`=0, `out_valid`=0, `in_ready`=0, `busy`=0, `vect_out`=all zero.
- `rst` has priority over `en` and every other input. Reset mid-LOAD or mid-HOLD discards partial data and zeroes the bank on the next edge.
- `start` at edge t: `in_ready` is high from cycle t+1, provided `en`=1.
- Element accepted at edge t is visible on `vect_out` from cycle t+1.
- Last element accepted at edge t: `out_valid` is high from cycle t+1.
- Minimum start-to-`out_valid` latency is `len_eff`+1 cycles, with `in_valid` held high.
- `out_ready`&`en` at edge t: `out_valid` is low from t+1. With `start` in the same cycle, `in_ready` is high from t+1, giving zero bubble between vectors.
- `in_ready` is combinational from state and `en` only. It never depends on `in_valid`.

## Configuration
- `VECT_ZERO_PAD_EN` defined: on entry to LOAD (from IDLE or HOLD), all `N_MAX` bank elements are cleared to zero in the same edge. Elements at index ≥ `len_q` in the presented vector are therefore zero.
- Not defined: no clear on entry. Elements at index ≥ `len_q` retain values from earlier vectors or from reset.

## Test plan
Bench configuration: `N_MAX`=4, WIDTH=43.
- Reset mid-LOAD after 2 elements accepted → next cycle: state IDLE, `vect_out`=0, `out_valid`=0, `in_ready`=0.
- `start` with `len`=4, stream 0x11,0x22,0x33,0x44 with `in_valid` held high → `out_valid` rises 5 cycles after `start`. `vect_out` elements 0..3 = 0x11..0x44, `out_len`=4.
- `len`=0 and `len`=9 → both load 4 elements, `out_len`=4.
- Load 0xA,0xB,0xC,0xD, then `len`=2 with 0x1,0x2 → elements {0x1,0x2,0xC,0xD} without `VECT_ZERO_PAD_EN`; {0x1,0x2,0,0} with it.
- HOLD with `out_ready`=0 for 3 cycles, then `out_ready` and `start`(`len`=1) in the same cycle → `out_valid` low and `in_ready` high on the next cycle. Element 0x7 accepted → `out_valid` returns one cycle later with `out_len`=1.
- `en`=0 for 2 cycles mid-LOAD with `in_valid`=1 → `in_ready`=0, `idx` and bank unchanged; loading resumes on the next cycle with `en`=1.

Source files
------------

// File: rtl/vect_stream_loader.sv
// Serial element stream to packed N_MAX*WIDTH vector loader (VECT_ZERO_PAD_EN: clear bank on LOAD entry).
// Latency: len_eff+1 cycles from start to out_valid when in_valid is held high; zero bubble between vectors.
// Backpressure: in_ready only in LOAD with en; vector held stable in HOLD until out_ready; en=0 freezes all.
module vect_stream_loader #(
    parameter int N_MAX = 4,
    parameter int WIDTH = 43,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_MAX*WIDTH-1:0] vect_out,
    output logic [LEN_W-1:0]       out_len
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [LEN_W-1:0]             idx_q;
    logic [LEN_W-1:0]             len_q;
    logic [LEN_W-1:0]             out_len_q;
    logic                         out_valid_q;
    logic [N_MAX-1:0][WIDTH-1:0]  bank_q;

    logic [LEN_W-1:0]             len_eff;
    logic                         accept;
    logic                         last_accept;
    logic                         release_vec;
    logic                         enter_load;

    // Zero or oversize lengths fall back to a full vector.
    assign len_eff = ((len == '0) || (len > LEN_W'(N_MAX))) ? LEN_W'(N_MAX) : len;

    assign in_ready    = (state_q == LOAD) && en;
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (idx_q == (len_q - LEN_W'(1)));
    assign release_vec = (state_q == HOLD) && out_ready && en;
    assign enter_load  = en && start && ((state_q == IDLE) || release_vec);

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_len   = out_len_q;
    assign vect_out  = bank_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                IDLE: if (start) state_d = LOAD;
                LOAD: if (last_accept) state_d = HOLD;
                HOLD: if (out_ready) state_d = start ? LOAD : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            len_q       <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
            bank_q      <= '0;
        end else if (en) begin
            if (enter_load) begin
                len_q <= len_eff;
                idx_q <= '0;
`ifdef VECT_ZERO_PAD_EN
                bank_q <= '0;
`endif
            end else if (accept) begin
                idx_q <= idx_q + LEN_W'(1);
                for (int i = 0; i < N_MAX; i++) begin
                    if (idx_q == LEN_W'(i)) begin
                        bank_q[i] <= in_data;
                    end
                end
            end

            if (last_accept) begin
                out_len_q   <= len_q;
                out_valid_q <= 1'b1;
            end else if (release_vec) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vect_stream_loader.sv
// Directed bench for vect_stream_loader with N_MAX=4, WIDTH=43.
module tb_vect_stream_loader;

    localparam int N_MAX = 4;
    localparam int WIDTH = 43;
    localparam int LEN_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic                   start;
    logic [LEN_W-1:0]       len;
    logic                   busy;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [N_MAX*WIDTH-1:0] vect_out;
    logic [LEN_W-1:0]       out_len;

    int n_chk  = 0;
    int n_pass = 0;

    vect_stream_loader #(.N_MAX(N_MAX), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vect_out  (vect_out),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] elem(input int i);
        return 64'(vect_out[i*WIDTH +: WIDTH]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then stream n elements with in_valid held high.
    task automatic load_vec(input logic [LEN_W-1:0] l, input int n,
                            input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                            input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
        logic [WIDTH-1:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        start = 1'b1;
        len   = l;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            in_data = d[k];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic release_hold();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_len",   64'(out_len),   64'd0);
        chk("rst_vect_zero", 64'(vect_out == '0), 64'd1);

        // Full-length load with exact latency: start edge + 4 accept edges.
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        chk("ld4_in_ready_after_start", 64'(in_ready), 64'd1);
        chk("ld4_busy", 64'(busy), 64'd1);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 43'h11 * 43'(k + 1);
            if (k == 3) chk("ld4_no_early_valid", 64'(out_valid), 64'd0);
            step();
        end
        in_valid = 1'b0;
        chk("ld4_out_valid", 64'(out_valid), 64'd1);
        chk("ld4_hold_in_ready", 64'(in_ready), 64'd0);
        chk("ld4_out_len", 64'(out_len), 64'd4);
        chk("ld4_e0", elem(0), 64'h11);
        chk("ld4_e1", elem(1), 64'h22);
        chk("ld4_e2", elem(2), 64'h33);
        chk("ld4_e3", elem(3), 64'h44);
        release_hold();
        chk("ld4_released", 64'(out_valid), 64'd0);
        chk("ld4_idle", 64'(busy), 64'd0);

        // len=0 and len=9 both clamp to N_MAX.
        load_vec(8'd0, 4, 43'h501, 43'h502, 43'h503, 43'h504);
        chk("len0_out_valid", 64'(out_valid), 64'd1);
        chk("len0_out_len", 64'(out_len), 64'd4);
        chk("len0_e3", elem(3), 64'h504);
        release_hold();
        load_vec(8'd9, 4, 43'h901, 43'h902, 43'h903, 43'h904);
        chk("len9_out_valid", 64'(out_valid), 64'd1);
        chk("len9_out_len", 64'(out_len), 64'd4);
        chk("len9_e0", elem(0), 64'h901);
        chk("len9_e3", elem(3), 64'h904);
        release_hold();

        // Short vector after a full one: tail elements depend on zero padding.
        load_vec(8'd4, 4, 43'hA, 43'hB, 43'hC, 43'hD);
        release_hold();
        load_vec(8'd2, 2, 43'h1, 43'h2, 43'h0, 43'h0);
        chk("short_out_valid", 64'(out_valid), 64'd1);
        chk("short_out_len", 64'(out_len), 64'd2);
        chk("short_e0", elem(0), 64'h1);
        chk("short_e1", elem(1), 64'h2);
`ifdef VECT_ZERO_PAD_EN
        chk("short_e2", elem(2), 64'h0);
        chk("short_e3", elem(3), 64'h0);
`else
        chk("short_e2", elem(2), 64'hC);
        chk("short_e3", elem(3), 64'hD);
`endif

        // HOLD stalls for 3 cycles; a start without out_ready is dropped.
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        step();
        step();
        chk("hold_valid_kept", 64'(out_valid), 64'd1);
        chk("hold_len_kept", 64'(out_len), 64'd2);
        chk("hold_no_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1; start = 1'b1; len = 8'd1;
        step();
        out_ready = 1'b0; start = 1'b0;
        chk("b2b_out_valid_low", 64'(out_valid), 64'd0);
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = 43'h7;
        step();
        in_valid = 1'b0;
        chk("b2b_out_valid", 64'(out_valid), 64'd1);
        chk("b2b_out_len", 64'(out_len), 64'd1);
        chk("b2b_e0", elem(0), 64'h7);
`ifdef VECT_ZERO_PAD_EN
        chk("b2b_e1", elem(1), 64'h0);
`else
        chk("b2b_e1", elem(1), 64'h2);
`endif
        release_hold();

        // en=0 for two cycles mid-LOAD with in_valid high.
        load_vec(8'd4, 2, 43'h100, 43'h101, 43'h0, 43'h0);
        in_valid = 1'b1; in_data = 43'h999; en = 1'b0;
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        step();
        step();
        chk("stall_busy", 64'(busy), 64'd1);
        chk("stall_out_valid", 64'(out_valid), 64'd0);
`ifdef VECT_ZERO_PAD_EN
        chk("stall_e2", elem(2), 64'h0);
`else
        chk("stall_e2", elem(2), 64'hC);
`endif
        en = 1'b1; in_data = 43'h102;
        #1;
        chk("resume_in_ready", 64'(in_ready), 64'd1);
        step();
        in_data = 43'h103;
        step();
        in_valid = 1'b0;
        chk("resume_out_valid", 64'(out_valid), 64'd1);
        chk("resume_e1", elem(1), 64'h101);
        chk("resume_e2", elem(2), 64'h102);
        chk("resume_e3", elem(3), 64'h103);
        out_ready = 1'b1; en = 1'b0;
        step();
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
        en = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold_release", 64'(out_valid), 64'd0);

        // Reset after two accepted elements discards everything.
        load_vec(8'd4, 2, 43'h55, 43'h66, 43'h0, 43'h0);
        chk("pre_rst_e1", elem(1), 64'h66);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_vect_zero", 64'(vect_out == '0), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);

        // in_valid in IDLE writes nothing.
        in_valid = 1'b1; in_data = 43'h3AB;
        step();
        in_valid = 1'b0;
        chk("idle_ignore_e0", elem(0), 64'h0);
        chk("idle_ignore_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
